// File: rtl/tone_pkg.sv
// Shared state encoding and default 12 MHz half-period constants for the
// buzzer tone sequencer.
package tone_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PLAY = 2'd1,
      ST_GAP  = 2'd2
   } tone_state_t;

   localparam int CLK_HZ = 12_000_000;

   // Half-period in clk cycles of a square wave at freq_hz.
   function automatic int half_period(input int freq_hz);
      return CLK_HZ / (2 * freq_hz);
   endfunction

   localparam int F_1KHZ_HALF = half_period(1000);
   localparam int F_2KHZ_HALF = half_period(2000);
   localparam int F_3KHZ_HALF = half_period(3000);
   localparam int F_4KHZ_HALF = half_period(4000);

endpackage

// File: rtl/tone_divider.sv
// Loadable half-period down-counter producing a square wave; half == 0 is a
// rest (wave held low). clr restarts the phase with the wave low.
module tone_divider
   import tone_pkg::*;
#(
   parameter int DIV_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic [DIV_W-1:0] half,
   output logic             wave
);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             wave_q, wave_d;
   logic [DIV_W-1:0] reload;

   always_comb begin
      reload = (half == '0) ? '0 : half - DIV_W'(1);
      cnt_d  = cnt_q;
      wave_d = wave_q;
      if (clr || half == '0) begin
         cnt_d  = reload;
         wave_d = 1'b0;
      end else if (cnt_q == '0) begin
         cnt_d  = reload;
         wave_d = ~wave_q;
      end else begin
         cnt_d  = cnt_q - DIV_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         wave_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         wave_q <= wave_d;
      end
   end

   assign wave = wave_q;

endmodule

// File: rtl/tone_sequencer.sv
// Buzzer tone sequencer: steps through TONE_HALF, holding each tone for DWELL
// cycles. Define TONE_GAP_EN to insert GAP silent cycles between steps.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | stopped, out low, waiting for en
// ST_PLAY | playing tone TONE_HALF[step] for DWELL cycles
// ST_GAP  | silent busy interval before the next step (TONE_GAP_EN only)
module tone_sequencer
   import tone_pkg::*;
#(
   parameter int N_TONES = 4,
   parameter int DIV_W   = 16,
   parameter logic [N_TONES*DIV_W-1:0] TONE_HALF = {16'(F_4KHZ_HALF), 16'(F_3KHZ_HALF),
                                                    16'(F_2KHZ_HALF), 16'(F_1KHZ_HALF)},
   parameter int DWELL   = 12_000_000,
   parameter int DWELL_W = 24,
   parameter int GAP     = 1_200_000,
   localparam int STEP_W = (N_TONES > 2) ? $clog2(N_TONES) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              loop,
   output logic              out,
   output logic [STEP_W-1:0] step,
   output logic              busy,
   output logic              done
);

   localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DWELL - 1);
   localparam logic [STEP_W-1:0]  LAST_STEP  = STEP_W'(N_TONES - 1);
`ifdef TONE_GAP_EN
   localparam logic [DWELL_W-1:0] GAP_LOAD   = DWELL_W'(GAP - 1);
`else
   logic unused_gap;
   assign unused_gap = (GAP > 0);
`endif

   tone_state_t       state_q, state_d;
   logic [STEP_W-1:0] step_q, step_d;
   logic [DWELL_W-1:0] dwell_q, dwell_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              tone_clr;
   logic [DIV_W-1:0]  tone_half;
   logic [DIV_W-1:0]  half_tab [N_TONES];

   for (genvar i = 0; i < N_TONES; i++) begin : g_tab
      assign half_tab[i] = TONE_HALF[i*DIV_W +: DIV_W];
   end

   // Divider is told the half-period of the step being entered so that a
   // phase restart loads the new tone in the same edge as the step update.
   assign tone_half = half_tab[step_d];

   always_comb begin
      state_d  = state_q;
      step_d   = step_q;
      dwell_d  = dwell_q;
      done_d   = 1'b0;
      tone_clr = 1'b1;
      case (state_q)
         ST_IDLE: begin
            step_d  = '0;
            dwell_d = '0;
            if (en) begin
               state_d = ST_PLAY;
               dwell_d = DWELL_LOAD;
            end
         end
         ST_PLAY: begin
            if (!en) begin
               state_d = ST_IDLE;
               step_d  = '0;
               dwell_d = '0;
            end else if (dwell_q == '0) begin
               if (step_q == LAST_STEP && !loop) begin
                  state_d = ST_IDLE;
                  step_d  = '0;
                  dwell_d = '0;
                  done_d  = 1'b1;
               end else begin
                  step_d = (step_q == LAST_STEP) ? '0 : step_q + STEP_W'(1);
`ifdef TONE_GAP_EN
                  state_d = ST_GAP;
                  dwell_d = GAP_LOAD;
`else
                  dwell_d = DWELL_LOAD;
`endif
               end
            end else begin
               dwell_d  = dwell_q - DWELL_W'(1);
               tone_clr = 1'b0;
            end
         end
`ifdef TONE_GAP_EN
         ST_GAP: begin
            if (!en) begin
               state_d = ST_IDLE;
               step_d  = '0;
               dwell_d = '0;
            end else if (dwell_q == '0) begin
               state_d = ST_PLAY;
               dwell_d = DWELL_LOAD;
            end else begin
               dwell_d = dwell_q - DWELL_W'(1);
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
            step_d  = '0;
            dwell_d = '0;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         step_q  <= '0;
         dwell_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         dwell_q <= dwell_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   tone_divider #(
      .DIV_W (DIV_W)
   ) u_divider (
      .clk  (clk),
      .rst  (rst),
      .clr  (tone_clr),
      .half (tone_half),
      .wave (out)
   );

   assign step = step_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: doc/tone_sequencer.md
Name: tone_sequencer

Overview:
Parametrised buzzer tone sequencer for the 12 MHz board clock. Steps through a table of N_TONES square-wave tones, holding each for a programmable dwell time. Supports one-shot or looping playback, rest slots and a start/stop control. Drives the buzzer pin directly and reports the current step index to LEDs or debug logic.

Parameters:
N_TONES, 4, number of table entries (2..16)
DIV_W, 16, width of each half-period value and of the tone counter
TONE_HALF, {16'd1500,16'd2000,16'd3000,16'd6000}, flattened N_TONES*DIV_W table of half-periods in clk cycles; entry 0 in the LSBs; defaults give 1/2/3/4 kHz at 12 MHz; value 0 = rest
DWELL, 12_000_000, clk cycles each step is held (>=2)
DWELL_W, 24, width of dwell counter; must hold DWELL-1
GAP, 1_200_000, silence cycles between steps (used only with TONE_GAP_EN; >=1)

Ports:
clk  in  1  board clock
rst  in  1  synchronous, active-high reset
en  in  1  level: 1 = play, 0 = stop
loop  in  1  sampled at the last step: 1 = wrap to step 0, 0 = stop after the last step
out  out  1  square-wave buzzer drive
step  out  $clog2(N_TONES)  index of the step being played
busy  out  1  high while in PLAY (or GAP)
done  out  1  one-cycle pulse at the end of a one-shot sequence

Behaviour:
- Reset: state=IDLE; out=0, step=0, busy=0, done=0; all counters 0. Reset wins over every other input in the same cycle, including mid-sequence.
- All outputs are registered.
- IDLE: out=0, busy=0, step=0.
  - en=1 -> PLAY next cycle: step=0, tone and dwell counters cleared, out=0.
- PLAY: busy=1.
  - Tone counter counts 0..H-1, where H = TONE_HALF[step]. At H-1 it toggles out and clears. First toggle is H cycles after step entry, so the period is 2H cycles.
  - H=0: out held 0, tone counter held 0 (rest slot).
  - Dwell counter counts 0..DWELL-1.
  - At DWELL-1 with step<N_TONES-1: step+1; tone counter cleared; out=0 on the next cycle (phase restarts every step).
  - At DWELL-1 with step==N_TONES-1 and loop=1: step=0 and playback continues. Same phase restart; no done pulse.
  - At DWELL-1 with step==N_TONES-1 and loop=0: done=1 for one cycle; -> IDLE; out=0, step=0, busy=0.
- en=0 while in PLAY or GAP: -> IDLE next cycle; out=0; no done pulse. en=1 again restarts from step 0.
- en held 1 after a one-shot finishes: the sequence restarts in the cycle after done (IDLE sees en=1).
- Dwell boundary coinciding with a tone toggle: the dwell transition wins, and out=0 on the next cycle.
- Arithmetic: unsigned counters, no wrap beyond terminal values. step width is $clog2(N_TONES), minimum 1.

Optional Feature:
- Macro: TONE_GAP_EN.
- Defined: adds state GAP. Each dwell expiry that would advance or wrap goes to GAP instead, with step already updated. GAP lasts GAP cycles with out=0 and busy=1, then -> PLAY with counters cleared. The final one-shot step goes straight to IDLE/done (no trailing gap). en=0 in GAP -> IDLE.
- Undefined: no GAP state; steps are back-to-back as described above.

Decomposition:
- Package tone_pkg: state encoding (IDLE, PLAY, GAP); default 12 MHz constants F_1KHZ_HALF=6000, F_2KHZ_HALF=3000, F_3KHZ_HALF=2000, F_4KHZ_HALF=1500; clk frequency constant.
- One sub-module, tone_divider: loadable half-period counter with inputs clk, rst, clr, half[DIV_W]; output wave. Implements the toggle and rest (half=0) rules.
- Top level holds the FSM, the dwell/gap counter and table indexing.

Test Plan:
- Bench parameters: DWELL=20, TONE_HALF={5,0,3,2}, GAP=4.
- en=1, loop=0 from reset -> busy next cycle.
  - step 0: out toggles every 2 cycles; step 1: out toggles every 3 cycles; step 2: out stays 0; step 3: out toggles every 5 cycles.
  - step 0..3 each held 20 cycles; done pulses once at cycle 80; then busy=0, out=0, step=0.
- en=1, loop=1 for 200 cycles -> step sequence 0,1,2,3,0,1,2,3,0,1; done never asserts.
- en dropped to 0 at step 2, cycle 5 -> next cycle out=0, busy=0, step=0, no done. Re-raise en -> restarts at step 0.
- rst pulsed mid-step 1 with en still 1 -> outputs at reset values that cycle. Playback restarts at step 0 the cycle after rst falls.
- TONE_GAP_EN defined, loop=0 -> 4 silent busy cycles between steps 0/1, 1/2 and 2/3; no gap after step 3; done at cycle 92.
